// File: rtl/capp_pkg.sv
// capp_pkg: shared types and helpers for the CAPP command sequencer.
//   cmd_op_t  : command opcodes carried on cmd_op
//   state_t   : sequencer FSM states
//   dual_rail : encodes (data, mask) into the per-bit two-rail line format
package capp_pkg;

   // Widest word the dual_rail helper encodes; the sequencer's WORD_W must match it.
   localparam int unsigned CAPP_WORD_W = 32;

   typedef enum logic [1:0] {
      OP_NOP    = 2'd0,
      OP_SEARCH = 2'd1,
      OP_WRITE  = 2'd2,
      OP_READ   = 2'd3
   } cmd_op_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_DRIVE   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_RESP    = 2'd3
   } state_t;

   // [2j] = enabled and 1, [2j+1] = enabled and 0; masked-off bits drive neither rail.
   function automatic logic [2*CAPP_WORD_W-1:0] dual_rail(
      input logic [CAPP_WORD_W-1:0] data,
      input logic [CAPP_WORD_W-1:0] mask
   );
      logic [2*CAPP_WORD_W-1:0] r;
      r = '0;
      for (int unsigned j = 0; j < CAPP_WORD_W; j++) begin
         r[2*j]   = mask[j] & data[j];
         r[2*j+1] = mask[j] & ~data[j];
      end
      return r;
   endfunction

endpackage

// File: rtl/capp_popcount.sv
// capp_popcount: combinational population count of a tag vector.
//   vec     in   N                  per-word match flags
//   count_c out  $clog2(N+1)        number of set bits (unregistered)
module capp_popcount #(
   parameter int unsigned N = 5
) (
   input  logic [N-1:0]             vec,
   output logic [$clog2(N+1)-1:0]   count_c
);

   localparam int unsigned CW = $clog2(N + 1);

   // Simple ripple sum; N is the word count of a small array.
   always_comb begin
      count_c = '0;
      for (int unsigned i = 0; i < N; i++) begin
         count_c = count_c + CW'(vec[i]);
      end
   end

endmodule

// File: rtl/capp_sequencer.sv
// capp_sequencer: command front-end for the CAPP cell array.
//   Accepts SEARCH/WRITE/READ over valid/ready, drives dual-rail match/write
//   lines for SETTLE_CYC cycles, samples tags/read_lines and returns one
//   response per command. The last search pattern is held so WRITE/READ act
//   on the currently tagged words.
// Ports:
//   clk, rst                      clock, async active-high reset
//   cmd_valid/cmd_ready           command handshake (ready only in IDLE)
//   cmd_op, cmd_data, cmd_mask    opcode, comparand/write value, bit enables
//   match_lines, write_lines      dual-rail lines to the cell array
//   tags, read_lines              per-word match flags / wired-OR read data
//   rsp_valid/rsp_ready           response handshake
//   rsp_tags, rsp_data            sampled tags / sampled read data (READ only)
//   busy                          FSM not in IDLE
//   rsp_count                     popcount of sampled tags (CAPP_TAG_COUNT_EN only)
// Configuration macro: CAPP_TAG_COUNT_EN adds rsp_count and the popcount unit.
module capp_sequencer
   import capp_pkg::*;
#(
   parameter int unsigned WORD_W     = CAPP_WORD_W,
   parameter int unsigned NUM_WORDS  = 5,
   parameter int unsigned SETTLE_CYC = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_op,
   input  logic [WORD_W-1:0]     cmd_data,
   input  logic [WORD_W-1:0]     cmd_mask,
   output logic [2*WORD_W-1:0]   match_lines,
   output logic [2*WORD_W-1:0]   write_lines,
   input  logic [NUM_WORDS-1:0]  tags,
   input  logic [WORD_W-1:0]     read_lines,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [NUM_WORDS-1:0]  rsp_tags,
   output logic [WORD_W-1:0]     rsp_data,
   output logic                  busy
`ifdef CAPP_TAG_COUNT_EN
   ,
   output logic [$clog2(NUM_WORDS+1)-1:0] rsp_count
`endif
);

   localparam int unsigned LINE_W = 2 * WORD_W;
   localparam int unsigned CNT_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   cmd_op_t              op_q, op_d;
   logic [LINE_W-1:0]    held_match, held_d;
   logic [LINE_W-1:0]    wr_d;
   logic                 cmd_ready_d, busy_d, rsp_valid_d;
   logic [NUM_WORDS-1:0] rsp_tags_d;
   logic [WORD_W-1:0]    rsp_data_d;
   logic [LINE_W-1:0]    enc;
   logic                 accept;

   // Dual-rail form of the incoming command (SEARCH pattern or WRITE pulse).
   assign enc    = dual_rail(CAPP_WORD_W'(cmd_data), CAPP_WORD_W'(cmd_mask));
   assign accept = cmd_valid & cmd_ready;

   // Cells retain their tags, so the match pattern stays on the lines in every state.
   assign match_lines = held_match;

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      op_d        = op_q;
      held_d      = held_match;
      wr_d        = '0;
      rsp_valid_d = rsp_valid;
      rsp_tags_d  = rsp_tags;
      rsp_data_d  = rsp_data;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               op_d  = cmd_op_t'(cmd_op);
               cnt_d = CNT_W'(SETTLE_CYC - 1);
               case (cmd_op_t'(cmd_op))
                  OP_SEARCH: begin
                     held_d  = enc;
                     state_d = ST_DRIVE;
                  end
                  OP_WRITE: begin
                     wr_d    = enc;
                     state_d = ST_DRIVE;
                  end
                  OP_READ:  state_d = ST_DRIVE;
                  default:  state_d = ST_IDLE;
               endcase
            end
         end
         ST_DRIVE: begin
            // Write pulse is held only while the settle counter runs.
            if (cnt_q == '0) begin
               state_d = ST_CAPTURE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
               wr_d  = write_lines;
            end
         end
         ST_CAPTURE: begin
            rsp_tags_d  = tags;
            rsp_data_d  = (op_q == OP_READ) ? read_lines : '0;
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      cmd_ready_d = (state_d == ST_IDLE);
      busy_d      = (state_d != ST_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         op_q        <= OP_NOP;
         held_match  <= '0;
         write_lines <= '0;
         cmd_ready   <= 1'b1;
         busy        <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_tags    <= '0;
         rsp_data    <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         held_match  <= held_d;
         write_lines <= wr_d;
         cmd_ready   <= cmd_ready_d;
         busy        <= busy_d;
         rsp_valid   <= rsp_valid_d;
         rsp_tags    <= rsp_tags_d;
         rsp_data    <= rsp_data_d;
      end
   end

`ifdef CAPP_TAG_COUNT_EN
   logic [$clog2(NUM_WORDS+1)-1:0] count_c;

   capp_popcount #(.N(NUM_WORDS)) u_popcount (
      .vec     (tags),
      .count_c (count_c)
   );

   // Tag count is captured alongside rsp_tags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_count <= '0;
      end else if (state_q == ST_CAPTURE) begin
         rsp_count <= count_c;
      end
   end
`endif

endmodule

// File: tb/tb_capp_sequencer.sv
// tb_capp_sequencer: self-checking bench for capp_sequencer with a behavioural
// model of the command rules (held search pattern, write pulse, response fields).
module tb_capp_sequencer;

   localparam int unsigned WORD_W     = 32;
   localparam int unsigned NUM_WORDS  = 5;
   localparam int unsigned SETTLE_CYC = 2;
   localparam int unsigned LINE_W     = 2 * WORD_W;
   localparam int          LAT        = SETTLE_CYC + 2;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 cmd_valid, cmd_ready, rsp_valid, rsp_ready, busy;
   logic [1:0]           cmd_op;
   logic [WORD_W-1:0]    cmd_data, cmd_mask, read_lines, rsp_data;
   logic [LINE_W-1:0]    match_lines, write_lines;
   logic [NUM_WORDS-1:0] tags, rsp_tags;
`ifdef CAPP_TAG_COUNT_EN
   logic [$clog2(NUM_WORDS+1)-1:0] rsp_count;
`endif

   int checks = 0;
   int errors = 0;
   logic [LINE_W-1:0] m_held;

   always #5 clk = ~clk;

   capp_sequencer #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS), .SETTLE_CYC(SETTLE_CYC)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
      .match_lines(match_lines), .write_lines(write_lines),
      .tags(tags), .read_lines(read_lines),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_tags(rsp_tags), .rsp_data(rsp_data), .busy(busy)
`ifdef CAPP_TAG_COUNT_EN
      , .rsp_count(rsp_count)
`endif
   );

   function automatic logic [LINE_W-1:0] ref_rail(input logic [WORD_W-1:0] d, input logic [WORD_W-1:0] m);
      logic [LINE_W-1:0] r;
      for (int j = 0; j < int'(WORD_W); j++) begin
         r[2*j]   = m[j] && d[j];
         r[2*j+1] = m[j] && !d[j];
      end
      return r;
   endfunction

   function automatic int popcnt(input logic [NUM_WORDS-1:0] v);
      int n = 0;
      for (int i = 0; i < int'(NUM_WORDS); i++) n += int'(v[i]);
      return n;
   endfunction

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (cmd_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   // Issue one command and observe every cycle until the response appears.
   task automatic run_cmd(input logic [1:0] op, input logic [WORD_W-1:0] d, input logic [WORD_W-1:0] m,
                          input bit early_ready, input bit junk,
                          output int lat, output int wr_cycles, output bit wr_bad, output bit ml_bad,
                          output bit started);
      logic [LINE_W-1:0] wr_exp;
      wait_idle(started);
      rsp_ready = early_ready;
      cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_mask = m;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      if (op == 2'd1) m_held = ref_rail(d, m);
      wr_exp = (op == 2'd2) ? ref_rail(d, m) : '0;
      lat = 1; wr_cycles = 0; wr_bad = 1'b0; ml_bad = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (write_lines !== '0) begin
            wr_cycles++;
            if (write_lines !== wr_exp) wr_bad = 1'b1;
         end
         if (match_lines !== m_held) ml_bad = 1'b1;
         if (rsp_valid === 1'b1) break;
         if (junk) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_op = 2'($urandom); cmd_data = $urandom; cmd_mask = $urandom;
         end
         @(posedge clk); #1;
         lat++;
      end
      cmd_valid = 1'b0;
   endtask

   // Hold off the response for 'hold' cycles, then complete one handshake.
   task automatic finish_rsp(input int hold, output bit unstable, output bit ready_seen);
      logic [NUM_WORDS-1:0] t;
      logic [WORD_W-1:0]    d;
      t = rsp_tags; d = rsp_data;
      unstable = 1'b0; ready_seen = 1'b0;
      rsp_ready = 1'b0;
      repeat (hold) begin
         @(posedge clk); #1;
         if (rsp_valid !== 1'b1 || rsp_tags !== t || rsp_data !== d) unstable = 1'b1;
         if (cmd_ready !== 1'b0 || busy !== 1'b1) ready_seen = 1'b1;
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset;
      #12;
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b exp 1", cmd_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b exp 0", rsp_valid); end
      checks++; if (match_lines !== '0 || write_lines !== '0) begin errors++; $display("FAIL reset_lines: got %h/%h exp 0/0", match_lines, write_lines); end
      checks++; if (rsp_tags !== '0 || rsp_data !== '0) begin errors++; $display("FAIL reset_rsp: got %h/%h exp 0/0", rsp_tags, rsp_data); end
      @(posedge clk); #1;
      rst = 1'b0;
      m_held = '0;
      @(posedge clk); #1;
   endtask

   task automatic test_search;
      int lat, wc; bit wb, mb, st, us, rs;
      tags = 5'b10110; read_lines = 32'h1234_5678;
      run_cmd(2'd1, 32'h0000_0005, 32'h0000_000F, 1'b0, 1'b0, lat, wc, wb, mb, st);
      checks++; if (!st) begin errors++; $display("FAIL search_start: got not-ready exp ready"); end
      checks++; if (match_lines !== 64'h99) begin errors++; $display("FAIL search_match: got %h exp 99", match_lines); end
      checks++; if (mb) begin errors++; $display("FAIL search_match_hold: got changing lines exp %h", m_held); end
      checks++; if (lat !== LAT) begin errors++; $display("FAIL search_latency: got %0d exp %0d", lat, LAT); end
      checks++; if (wc !== 0) begin errors++; $display("FAIL search_no_write: got %0d exp 0", wc); end
      checks++; if (rsp_tags !== 5'b10110) begin errors++; $display("FAIL search_tags: got %b exp 10110", rsp_tags); end
      checks++; if (rsp_data !== '0) begin errors++; $display("FAIL search_data: got %h exp 0", rsp_data); end
`ifdef CAPP_TAG_COUNT_EN
      checks++; if (rsp_count !== 3'd3) begin errors++; $display("FAIL search_count: got %0d exp 3", rsp_count); end
`endif
      finish_rsp(0, us, rs);
      checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL search_done: got v%b r%b b%b exp v0 r1 b0", rsp_valid, cmd_ready, busy); end
   endtask

   task automatic test_write;
      int lat, wc; bit wb, mb, st, us, rs;
      tags = 5'b00011;
      run_cmd(2'd2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat, wc, wb, mb, st);
      checks++; if (wc !== SETTLE_CYC || wb) begin errors++; $display("FAIL write_pulse: got %0d cycles bad=%b exp %0d cycles of 1", wc, wb, SETTLE_CYC); end
      checks++; if (mb || match_lines !== 64'h99) begin errors++; $display("FAIL write_match_hold: got %h exp 99", match_lines); end
      checks++; if (write_lines !== '0) begin errors++; $display("FAIL write_release: got %h exp 0", write_lines); end
      checks++; if (rsp_data !== '0 || rsp_tags !== 5'b00011) begin errors++; $display("FAIL write_rsp: got %h/%b exp 0/00011", rsp_data, rsp_tags); end
      finish_rsp(0, us, rs);
   endtask

   task automatic test_read_backpressure;
      int lat, wc; bit wb, mb, st, us, rs;
      tags = 5'b00100; read_lines = 32'hDEAD_BEEF;
      run_cmd(2'd3, 32'h0, 32'h0, 1'b0, 1'b0, lat, wc, wb, mb, st);
      checks++; if (rsp_data !== 32'hDEAD_BEEF || rsp_tags !== 5'b00100) begin errors++; $display("FAIL read_rsp: got %h/%b exp deadbeef/00100", rsp_data, rsp_tags); end
      checks++; if (wc !== 0 || mb) begin errors++; $display("FAIL read_lines: got wr=%0d mbad=%b exp 0/0", wc, mb); end
      read_lines = 32'h0; tags = 5'b11111;
      finish_rsp(5, us, rs);
      checks++; if (us) begin errors++; $display("FAIL bp_stable: got changing rsp exp stable"); end
      checks++; if (rs) begin errors++; $display("FAIL bp_cmd_ready: got ready/idle exp busy"); end
      checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got v%b r%b exp v0 r1", rsp_valid, cmd_ready); end
   endtask

   task automatic test_early_ready;
      int lat, wc; bit wb, mb, st;
      tags = 5'b01001; read_lines = 32'hCAFE_0001;
      run_cmd(2'd3, 32'h0, 32'h0, 1'b1, 1'b0, lat, wc, wb, mb, st);
      checks++; if (lat !== LAT || rsp_data !== 32'hCAFE_0001) begin errors++; $display("FAIL early_ready: got lat %0d data %h exp %0d cafe0001", lat, rsp_data, LAT); end
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL early_ready_done: got v%b r%b exp v0 r1", rsp_valid, cmd_ready); end
   endtask

   task automatic test_nop;
      bit st, seen;
      wait_idle(st);
      cmd_valid = 1'b1; cmd_op = 2'd0; cmd_data = $urandom; cmd_mask = $urandom;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL nop_idle: got r%b b%b exp r1 b0", cmd_ready, busy); end
      seen = 1'b0;
      repeat (6) begin
         if (rsp_valid !== 1'b0 || match_lines !== m_held) seen = 1'b1;
         @(posedge clk); #1;
      end
      checks++; if (seen) begin errors++; $display("FAIL nop_no_rsp: got response or line change exp none"); end
   endtask

   task automatic test_reset_mid_write;
      bit st;
      logic [LINE_W-1:0] wexp;
      wait_idle(st);
      wexp = ref_rail(32'hA5A5_0F0F, 32'hFFFF_FFFF);
      cmd_valid = 1'b1; cmd_op = 2'd2; cmd_data = 32'hA5A5_0F0F; cmd_mask = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      checks++; if (write_lines !== wexp) begin errors++; $display("FAIL rstmid_pulse: got %h exp %h", write_lines, wexp); end
      #2 rst = 1'b1;
      #1;
      m_held = '0;
      checks++; if (write_lines !== '0 || match_lines !== '0) begin errors++; $display("FAIL rstmid_lines: got %h/%h exp 0/0", write_lines, match_lines); end
      checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl: got r%b b%b v%b exp r1 b0 v0", cmd_ready, busy, rsp_valid); end
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checks++; if (rsp_valid !== 1'b0 || write_lines !== '0) begin errors++; $display("FAIL rstmid_dropped: got v%b w%h exp v0 w0", rsp_valid, write_lines); end
   endtask

   task automatic test_random;
      int lat, wc, hold; bit wb, mb, st, us, rs;
      logic [1:0] op;
      logic [WORD_W-1:0] d, m;
      logic [LINE_W-1:0] wexp;
      for (int it = 0; it < 40; it++) begin
         op = 2'($urandom_range(1, 3));
         d = $urandom; m = (it % 5 == 0) ? '0 : $urandom;
         tags = NUM_WORDS'($urandom); read_lines = $urandom;
         hold = $urandom_range(0, 3);
         wexp = (op == 2'd2) ? ref_rail(d, m) : '0;
         run_cmd(op, d, m, 1'b0, 1'b1, lat, wc, wb, mb, st);
         checks++; if (!st || lat !== LAT) begin errors++; $display("FAIL rnd%0d_latency: got %0d exp %0d", it, lat, LAT); end
         checks++; if (wc !== ((wexp != '0) ? SETTLE_CYC : 0) || wb) begin errors++; $display("FAIL rnd%0d_write: got %0d bad=%b exp %0d", it, wc, wb, (wexp != '0) ? SETTLE_CYC : 0); end
         checks++; if (mb) begin errors++; $display("FAIL rnd%0d_match: got %h exp %h", it, match_lines, m_held); end
         checks++; if (rsp_tags !== tags) begin errors++; $display("FAIL rnd%0d_tags: got %b exp %b", it, rsp_tags, tags); end
         checks++; if (rsp_data !== ((op == 2'd3) ? read_lines : '0)) begin errors++; $display("FAIL rnd%0d_data: got %h exp %h", it, rsp_data, (op == 2'd3) ? read_lines : '0); end
`ifdef CAPP_TAG_COUNT_EN
         checks++; if (int'(rsp_count) !== popcnt(tags)) begin errors++; $display("FAIL rnd%0d_count: got %0d exp %0d", it, rsp_count, popcnt(tags)); end
`endif
         finish_rsp(hold, us, rs);
         checks++; if (us || rs || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL rnd%0d_handshake: got us%b rs%b v%b r%b exp 0 0 0 1", it, us, rs, rsp_valid, cmd_ready); end
      end
   endtask

   initial begin
      cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = '0; cmd_mask = '0;
      rsp_ready = 1'b0; tags = '0; read_lines = '0; m_held = '0;
      test_reset;
      test_search;
      test_write;
      test_read_backpressure;
      test_early_ready;
      test_nop;
      test_reset_mid_write;
      test_random;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout exp completion");
      $fatal(1, "watchdog expired");
   end

endmodule
